// File: rtl/stream_mux_pkg.sv
// Shared definitions for stream multiplexers and arbiters.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
  localparam int MAX_CH   = 32;

  // Result bit j is req[(start + j) mod n], so bit 0 is the highest-priority requester.
  function automatic logic [MAX_CH-1:0] rotate_req(input logic [MAX_CH-1:0] req,
                                                    input int unsigned       start,
                                                    input int unsigned       n);
    logic [MAX_CH-1:0] r;
    int unsigned       s;
    r = '0;
    for (int unsigned j = 0; j < n; j++) begin
      s = start + j;
      if (s >= n) s = s - n;
      r[j] = req[s];
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last granted channel.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic                grant_valid,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    w_start;
  logic [CHANNELS-1:0] w_rot;

  always_comb begin
    w_start = (r_ptr == SEL_W'(CHANNELS - 1)) ? '0 : r_ptr + SEL_W'(1);
    w_rot   = CHANNELS'(rotate_req(MAX_CH'(req), 32'(w_start), CHANNELS));
  end

  always_comb begin : find_grant
    int unsigned off;
    int unsigned sum;
    off = 0;
    for (int unsigned j = CHANNELS; j > 0; j--) begin
      if (w_rot[j-1]) off = j - 1;
    end
    sum = 32'(w_start) + off;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    grant_valid = |req;
    grant_idx   = SEL_W'(sum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= SEL_W'(CHANNELS - 1);
    end else if (advance && grant_valid) begin
      r_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel registered stream multiplexer; select-driven or round-robin arbitration.
module stream_mux_arb
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 4,
  parameter  int MODE     = MODE_SEL,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic             w_load;
  logic             w_gnt_valid;
  logic [SEL_W-1:0] w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;

  // Gated by rst_n so no producer sees ready while the stage is held in reset.
  assign w_load = rst_n && (!r_out_valid || out_ready);

  if (MODE == MODE_RR) begin : g_rr
    logic w_unused_sel;
    assign w_unused_sel = ^sel;

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (in_valid),
      .advance    (w_load),
      .grant_valid(w_gnt_valid),
      .grant_idx  (w_gnt_idx)
    );
  end else begin : g_sel
    assign w_gnt_idx = sel;

    always_comb begin
      w_gnt_valid = 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) w_gnt_valid = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready   = '0;
    w_gnt_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (w_gnt_idx == SEL_W'(i)) w_gnt_data = in_data[i*WIDTH +: WIDTH];
    end
    if (w_load && w_gnt_valid) in_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_load) begin
      if (w_gnt_valid) begin
        r_out_data  <= w_gnt_data;
        r_out_chan  <= w_gnt_idx;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb: select mode, round-robin mode and a 3-channel select instance.
module tb_stream_mux_arb;

  localparam int W  = 4;
  localparam int CH = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [CH*W-1:0] in_data;
  logic [CH-1:0]   in_valid;
  logic [SW-1:0]   sel;
  logic            out_ready;

  logic [CH-1:0]   s_in_ready, r_in_ready;
  logic [W-1:0]    s_out_data, r_out_data;
  logic [SW-1:0]   s_out_chan, r_out_chan;
  logic            s_out_valid, r_out_valid;

  logic [3*W-1:0]  t_in_data;
  logic [2:0]      t_in_valid, t_in_ready;
  logic [1:0]      t_sel, t_out_chan;
  logic [W-1:0]    t_out_data;
  logic            t_out_valid;

  stream_mux_arb #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .sel(sel), .out_data(s_out_data), .out_chan(s_out_chan), .out_valid(s_out_valid),
    .out_ready(out_ready));

  stream_mux_arb #(.WIDTH(W), .CHANNELS(CH), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(r_in_ready),
    .sel(sel), .out_data(r_out_data), .out_chan(r_out_chan), .out_valid(r_out_valid),
    .out_ready(out_ready));

  stream_mux_arb #(.WIDTH(W), .CHANNELS(3), .MODE(0)) u_sel3 (
    .clk(clk), .rst_n(rst_n), .in_data(t_in_data), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .sel(t_sel), .out_data(t_out_data), .out_chan(t_out_chan), .out_valid(t_out_valid),
    .out_ready(out_ready));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  valid;
    logic [15:0] data;
    logic        ordy;
    logic [3:0]  exp_rdy;
    logic        exp_ov;
    logic [3:0]  exp_od;
    logic [1:0]  exp_oc;
  } vec_t;

  vec_t       vt[7];
  logic [3:0] chd[4];
  int         fair_seq[6];

  initial begin
    // Channel data: ch3=D, ch2=A, ch1=5, ch0=C.
    chd = '{4'hC, 4'h5, 4'hA, 4'hD};
    vt[0] = '{2'd2, 4'b1111, 16'hDA5C, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
    vt[1] = '{2'd0, 4'b0001, 16'hDA5C, 1'b1, 4'b0001, 1'b1, 4'hC, 2'd0};
    vt[2] = '{2'd1, 4'b0001, 16'hDA5C, 1'b1, 4'b0000, 1'b0, 4'hC, 2'd0};
    vt[3] = '{2'd3, 4'b1000, 16'hDA5C, 1'b0, 4'b1000, 1'b1, 4'hD, 2'd3};
    vt[4] = '{2'd1, 4'b0010, 16'hDA5C, 1'b0, 4'b0000, 1'b1, 4'hD, 2'd3};
    vt[5] = '{2'd1, 4'b0010, 16'hDA5C, 1'b1, 4'b0010, 1'b1, 4'h5, 2'd1};
    vt[6] = '{2'd2, 4'b0000, 16'hDA5C, 1'b1, 4'b0000, 1'b0, 4'h5, 2'd1};
    fair_seq = '{1, 3, 1, 3, 1, 1};

    rst_n      = 1'b0;
    in_valid   = '1;
    in_data    = 16'hDA5C;
    sel        = 2'd0;
    out_ready  = 1'b1;
    t_in_valid = '1;
    t_in_data  = 12'h5C3;
    t_sel      = 2'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_s_rdy", 32'(s_in_ready), 0);
    check("rst_s_ov",  32'(s_out_valid), 0);
    check("rst_s_od",  32'(s_out_data), 0);
    check("rst_r_rdy", 32'(r_in_ready), 0);
    check("rst_r_ov",  32'(r_out_valid), 0);
    check("rst_r_od",  32'(r_out_data), 0);
    check("rst_r_oc",  32'(r_out_chan), 0);
    check("rst_t_rdy", 32'(t_in_ready), 0);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 7; i++) begin
      sel       = vt[i].sel;
      in_valid  = vt[i].valid;
      in_data   = vt[i].data;
      out_ready = vt[i].ordy;
      #1;
      check($sformatf("vec%0d_rdy", i), 32'(s_in_ready), 32'(vt[i].exp_rdy));
      @(posedge clk); #1;
      check($sformatf("vec%0d_ov", i), 32'(s_out_valid), 32'(vt[i].exp_ov));
      check($sformatf("vec%0d_od", i), 32'(s_out_data),  32'(vt[i].exp_od));
      check($sformatf("vec%0d_oc", i), 32'(s_out_chan),  32'(vt[i].exp_oc));
      @(negedge clk);
    end

    // Backpressure: load ch2, stall for 5 cycles, then release with ch0 pending.
    sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_load_od", 32'(s_out_data), 32'hA);
    @(negedge clk);
    out_ready = 1'b0; sel = 2'd0; in_valid = 4'b0101;
    for (int unsigned k = 0; k < 5; k++) begin
      in_data = {12'hDA5, 4'(k)};
      #1;
      check("bp_hold_rdy", 32'(s_in_ready), 0);
      @(posedge clk); #1;
      check("bp_hold_od", 32'(s_out_data), 32'hA);
      check("bp_hold_ov", 32'(s_out_valid), 1);
      @(negedge clk);
    end
    in_data = 16'hDA57; out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(s_in_ready), 32'b0001);
    @(posedge clk); #1;
    check("bp_rel_od", 32'(s_out_data), 32'h7);
    check("bp_rel_oc", 32'(s_out_chan), 0);
    check("bp_rel_ov", 32'(s_out_valid), 1);
    @(negedge clk);

    // Out-of-range select on the 3-channel instance.
    t_sel = 2'd3;
    #1;
    check("oor_rdy", 32'(t_in_ready), 0);
    @(posedge clk); #1;
    check("oor_ov", 32'(t_out_valid), 0);
    @(negedge clk);
    t_sel = 2'd2;
    #1;
    check("sel3_rdy", 32'(t_in_ready), 32'b100);
    @(posedge clk); #1;
    check("sel3_od", 32'(t_out_data), 32'h5);
    check("sel3_oc", 32'(t_out_chan), 2);
    @(negedge clk);

    // Round-robin: restart from reset, all channels valid.
    rst_n = 1'b0; in_valid = 4'b1111; in_data = 16'hDA5C; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      #1;
      check($sformatf("rr%0d_rdy", i), 32'(r_in_ready), 32'(4'b0001 << (i % 4)));
      @(posedge clk); #1;
      check($sformatf("rr%0d_oc", i), 32'(r_out_chan), i % 4);
      check($sformatf("rr%0d_od", i), 32'(r_out_data), 32'(chd[i % 4]));
      @(negedge clk);
    end

    // Fairness between ch1 and ch3, then ch3 drops.
    for (int unsigned i = 0; i < 6; i++) begin
      in_valid = (i < 4) ? 4'b1010 : 4'b0010;
      @(posedge clk); #1;
      check($sformatf("fair%0d_oc", i), 32'(r_out_chan), 32'(fair_seq[i]));
      check($sformatf("fair%0d_ov", i), 32'(r_out_valid), 1);
      @(negedge clk);
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov", 32'(r_out_valid), 0);
    check("arst_od", 32'(r_out_data), 0);
    check("arst_oc", 32'(r_out_chan), 0);
    rst_n = 1'b1;
    in_valid = 4'b1111;
    #1;
    check("arst_rdy", 32'(r_in_ready), 32'b0001);
    @(posedge clk); #1;
    check("arst_first_oc", 32'(r_out_chan), 0);
    check("arst_first_ov", 32'(r_out_valid), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
